// File: rtl/mig1_fetch_decode_execute.sv
// Mig1 datapath core: latches the fetched instruction, decodes its fields and
// evaluates the integer ALU and branch condition combinationally from it.
module mig1_fetch_decode_execute #(
  parameter int ADDR_WIDTH    = 32,
  parameter int INSN_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_WIDTH-1:0]    insn_addr,
  output logic [ADDR_WIDTH-1:0]    imem_addr,
  input  logic [INSN_WIDTH-1:0]    imem_data,
  output logic [INSN_WIDTH-1:0]    insn,
  output logic                     is_jump,
  output logic                     is_branch,
  output logic [RF_ADDR_WIDTH-1:0] rf_rd1,
  output logic [RF_ADDR_WIDTH-1:0] rf_rd2,
  output logic [RF_ADDR_WIDTH-1:0] rf_wr,
  output logic                     rf_wr_enable,
  input  logic [INSN_WIDTH-1:0]    operand1,
  input  logic [INSN_WIDTH-1:0]    operand2,
  output logic [INSN_WIDTH-1:0]    result,
  output logic                     illegal
);

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,
    OP_SLT  = 5'd9,
    OP_SLTU = 5'd10,
    OP_MOV  = 5'd11,
    OP_JMP  = 5'd12,
    OP_BEQ  = 5'd13,
    OP_BNE  = 5'd14
  } opcode_e;

  logic [INSN_WIDTH-1:0] insn_q;
  logic [INSN_WIDTH-1:0] insn_d;
  logic [4:0]            opcode_s;
  logic [4:0]            shamt_s;

  assign imem_addr = insn_addr;
  assign insn      = insn_q;
  assign opcode_s  = insn_q[31:27];
  assign shamt_s   = operand2[4:0];

  // Next fetched instruction: no stall, the memory word is taken every cycle.
  always_comb begin
    insn_d = imem_data;
  end

  // Instruction latch; reset discards whatever was in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      insn_q <= '0;
    end else begin
      insn_q <= insn_d;
    end
  end

  // Register-file addresses come straight from the fixed field positions.
  always_comb begin
    rf_wr  = insn_q[18 +: RF_ADDR_WIDTH];
    rf_rd1 = insn_q[9 +: RF_ADDR_WIDTH];
    rf_rd2 = insn_q[0 +: RF_ADDR_WIDTH];
  end

  // Opcode decode and ALU; anything undefined behaves as a NOP but is flagged.
  always_comb begin
    result       = '0;
    rf_wr_enable = 1'b0;
    is_jump      = 1'b0;
    is_branch    = 1'b0;
    illegal      = 1'b0;
    case (opcode_s)
      OP_NOP: begin
        result = '0;
      end
      OP_ADD: begin
        result       = operand1 + operand2;
        rf_wr_enable = 1'b1;
      end
      OP_SUB: begin
        result       = operand1 - operand2;
        rf_wr_enable = 1'b1;
      end
      OP_AND: begin
        result       = operand1 & operand2;
        rf_wr_enable = 1'b1;
      end
      OP_OR: begin
        result       = operand1 | operand2;
        rf_wr_enable = 1'b1;
      end
      OP_XOR: begin
        result       = operand1 ^ operand2;
        rf_wr_enable = 1'b1;
      end
      OP_SLL: begin
        result       = operand1 << shamt_s;
        rf_wr_enable = 1'b1;
      end
      OP_SRL: begin
        result       = operand1 >> shamt_s;
        rf_wr_enable = 1'b1;
      end
      OP_SRA: begin
        result       = $unsigned($signed(operand1) >>> shamt_s);
        rf_wr_enable = 1'b1;
      end
      OP_SLT: begin
        result       = {31'b0, ($signed(operand1) < $signed(operand2))};
        rf_wr_enable = 1'b1;
      end
      OP_SLTU: begin
        result       = {31'b0, (operand1 < operand2)};
        rf_wr_enable = 1'b1;
      end
      OP_MOV: begin
        result       = operand1;
        rf_wr_enable = 1'b1;
      end
      OP_JMP: begin
        is_jump = 1'b1;
      end
      OP_BEQ: begin
        is_branch = (operand1 == operand2);
      end
      OP_BNE: begin
        is_branch = (operand1 != operand2);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mig1_fetch_decode_execute.sv
// Bench for mig1_fetch_decode_execute: directed spot checks plus randomized
// instructions compared every cycle against an arithmetic reference model.
module tb_mig1_fetch_decode_execute;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] insn_addr = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] insn;
  logic        is_jump, is_branch, rf_wr_enable, illegal;
  logic [8:0]  rf_rd1, rf_rd2, rf_wr;
  logic [31:0] operand1 = 32'h0;
  logic [31:0] operand2 = 32'h0;
  logic [31:0] result;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_insn = 32'h0;
  bit          check_en = 1'b0;

  mig1_fetch_decode_execute dut (
    .clk(clk), .reset(reset), .insn_addr(insn_addr), .imem_addr(imem_addr),
    .imem_data(imem_data), .insn(insn), .is_jump(is_jump), .is_branch(is_branch),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rf_wr(rf_wr), .rf_wr_enable(rf_wr_enable),
    .operand1(operand1), .operand2(operand2), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the opcode table with plain arithmetic.
  function automatic logic [31:0] m_result(input logic [31:0] i, input logic [31:0] a,
                                           input logic [31:0] b);
    int unsigned op = i >> 27;
    int unsigned s  = b % 32;
    logic [31:0] ones = 32'hFFFF_FFFF;
    case (op)
      1:  return a + b;
      2:  return a + (~b) + 32'd1;
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return a * (32'd1 << s);
      7:  return a / (32'd1 << s);
      8:  return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
      9:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      10: return (a < b) ? 32'd1 : 32'd0;
      11: return a;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_wen(input logic [31:0] i);
    int unsigned op = i >> 27;
    return (op >= 1 && op <= 11);
  endfunction

  function automatic logic m_branch(input logic [31:0] i, input logic [31:0] a,
                                    input logic [31:0] b);
    int unsigned op = i >> 27;
    return (op == 13 && a == b) || (op == 14 && a != b);
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("insn", insn, exp_insn);
      chk("imem_addr", imem_addr, insn_addr);
      chk("rf_wr", {23'd0, rf_wr}, (exp_insn >> 18) & 32'h1FF);
      chk("rf_rd1", {23'd0, rf_rd1}, (exp_insn >> 9) & 32'h1FF);
      chk("rf_rd2", {23'd0, rf_rd2}, exp_insn & 32'h1FF);
      chk("rf_wr_enable", {31'd0, rf_wr_enable}, {31'd0, m_wen(exp_insn)});
      chk("is_jump", {31'd0, is_jump}, {31'd0, (exp_insn >> 27) == 32'd12});
      chk("is_branch", {31'd0, is_branch}, {31'd0, m_branch(exp_insn, operand1, operand2)});
      chk("illegal", {31'd0, illegal}, {31'd0, (exp_insn >> 27) >= 32'd15});
      chk("result", result, m_result(exp_insn, operand1, operand2));
    end
  end

  // Present one instruction and operands, let it latch, return just after the check edge.
  task automatic load(input logic [31:0] d, input logic [31:0] a, input logic [31:0] b);
    imem_data = d;
    operand1  = a;
    operand2  = b;
    @(posedge clk);
    exp_insn = reset ? d : 32'h0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d, a, b;
    logic [4:0]  op;

    // Model pinned against hand-computed values.
    chk("model_sra", m_result(32'h4000_0000, 32'h8000_0000, 32'h24), 32'hF800_0000);
    chk("model_slt", m_result(32'h4800_0000, 32'h1, 32'hFFFF_FFFF), 32'h0);
    chk("model_sub", m_result(32'h1000_0000, 32'h1, 32'hFFFF_FFFF), 32'h2);

    // Held in reset: instruction memory is ignored.
    check_en = 1'b1;
    for (int i = 0; i < 4; i++) load(32'h0804_0403, 32'h5, 32'h6);
    chk("rst_insn", insn, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_strobes", {28'd0, is_jump, is_branch, rf_wr_enable, illegal}, 32'h0);
    #2 reset = 1'b1;

    // ADD rd=1 rs1=2 rs2=3
    load(32'h0804_0403, 32'hFFFF_FFFF, 32'h2);
    chk("add_insn", insn, 32'h0804_0403);
    chk("add_rf", {5'd0, rf_wr, rf_rd1, rf_rd2}, {5'd0, 9'd1, 9'd2, 9'd3});
    chk("add_wen", {31'd0, rf_wr_enable}, 32'h1);
    chk("add_result", result, 32'h1);

    load(32'h1000_0000, 32'h1, 32'hFFFF_FFFF);
    chk("sub_result", result, 32'h2);
    load(32'h4800_0000, 32'h1, 32'hFFFF_FFFF);
    chk("slt_result", result, 32'h0);
    load(32'h5000_0000, 32'h1, 32'hFFFF_FFFF);
    chk("sltu_result", result, 32'h1);

    load(32'h4000_0000, 32'h8000_0000, 32'h24);
    chk("sra_result", result, 32'hF800_0000);
    load(32'h3800_0000, 32'h8000_0000, 32'h24);
    chk("srl_result", result, 32'h0800_0000);

    load(32'h6800_0000, 32'h5, 32'h5);
    chk("beq_taken", {31'd0, is_branch}, 32'h1);
    chk("beq_wen_result", {31'd0, rf_wr_enable} | result, 32'h0);
    operand2 = 32'h6;
    #1 chk("beq_not_taken", {31'd0, is_branch}, 32'h0);
    load(32'h7000_0000, 32'h5, 32'h6);
    chk("bne_taken", {31'd0, is_branch}, 32'h1);
    operand2 = 32'h5;
    #1 chk("bne_not_taken", {31'd0, is_branch}, 32'h0);
    load(32'h6000_0000, 32'h5, 32'h5);
    chk("jmp", {31'd0, is_jump}, 32'h1);
    chk("jmp_wen_result", {31'd0, rf_wr_enable} | result, 32'h0);

    load(32'hF800_0000, 32'h1234_5678, 32'h9);
    chk("illegal", {31'd0, illegal}, 32'h1);
    chk("illegal_wen_result", {31'd0, rf_wr_enable} | result, 32'h0);

    for (int i = 0; i < 8; i++) begin
      insn_addr = $urandom;
      #1 chk("imem_addr_sweep", imem_addr, insn_addr);
    end

    // Asynchronous reset mid-run clears the latch without a clock edge.
    load(32'h0804_0403, 32'h7, 32'h8);
    reset    = 1'b0;
    exp_insn = 32'h0;
    #1 chk("async_clear", insn, 32'h0);
    load(32'h0804_0403, 32'h7, 32'h8);
    chk("held_clear", insn, 32'h0);
    #1 reset = 1'b1;

    // Randomized instruction stream.
    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
      d  = {op, 27'($urandom)};
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      insn_addr = $urandom;
      load(d, a, b);
    end

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
